// File: rtl/feature_frame_loader_if.sv
// feature_frame_loader_if: handshake and frame bus between the feature
// producer, the decision-tree loader and the class consumer.
//   in_data/in_valid/in_last/in_ready : byte-serial feature stream (valid/ready)
//   features                          : parallel frame to the tree, X1 at LSBs
//   class_in                          : combinational class from the tree
//   class_out/class_valid/class_ack   : latched class to the consumer
//   frame_err                         : one-cycle pulse on misaligned in_last
// Modports: slave = loader side, master = producer/tree/consumer side.
interface feature_frame_loader_if #(
    parameter int unsigned NUM_FEATURES = 16,
    parameter int unsigned FEAT_W       = 8,
    parameter int unsigned CLASS_W      = 4
);
    logic [FEAT_W-1:0]              in_data;
    logic                           in_valid;
    logic                           in_last;
    logic                           in_ready;
    logic [NUM_FEATURES*FEAT_W-1:0] features;
    logic [CLASS_W-1:0]             class_in;
    logic [CLASS_W-1:0]             class_out;
    logic                           class_valid;
    logic                           class_ack;
    logic                           frame_err;

    modport slave (
        input  in_data, in_valid, in_last, class_in, class_ack,
        output in_ready, features, class_out, class_valid, frame_err
    );

    modport master (
        output in_data, in_valid, in_last, class_in, class_ack,
        input  in_ready, features, class_out, class_valid, frame_err
    );
endinterface

// File: rtl/feature_frame_loader.sv
// feature_frame_loader: assembles a byte-serial stream of NUM_FEATURES
// features into a parallel frame, holds it on the decision tree for
// SETTLE_CYCLES, then latches the tree's class and presents it until acked.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : feature_frame_loader_if.slave (stream in, frame out, class out)
module feature_frame_loader #(
    parameter int unsigned NUM_FEATURES  = 16,
    parameter int unsigned FEAT_W        = 8,
    parameter int unsigned CLASS_W       = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    feature_frame_loader_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEATURES - 1);
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        HOLD
    } state_t;

    state_t                               state;
    logic [IDX_W-1:0]                     index;
    logic [7:0]                           cnt;
    logic [NUM_FEATURES-1:0][FEAT_W-1:0]  slots;
    logic [CLASS_W-1:0]                   class_q;
    logic                                 class_valid_q;
    logic                                 frame_err_q;
    logic                                 ready_q;
    logic                                 last_slot;

    assign last_slot = (index == LAST_IDX);

    // ready_q mirrors (state == LOAD) but is kept as its own register so
    // in_ready is a clean flop output and reads 1 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LOAD;
            index         <= '0;
            cnt           <= '0;
            slots         <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            frame_err_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        slots[index] <= bus.in_data;
                        if (last_slot && bus.in_last) begin
                            index   <= '0;
                            cnt     <= SETTLE_INIT;
                            ready_q <= 1'b0;
                            state   <= SETTLE;
                        end else if (last_slot || bus.in_last) begin
                            // Misaligned frame: drop it and resync on the next byte.
                            index       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    // Counter runs SETTLE_CYCLES..0; the sample happens on the
                    // cycle after it hits 0, giving SETTLE_CYCLES+1 latency.
                    if (cnt == 8'd0) begin
                        class_q       <= bus.class_in;
                        class_valid_q <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (bus.class_ack && class_valid_q) begin
                        class_valid_q <= 1'b0;
                        ready_q       <= 1'b1;
                        state         <= LOAD;
                    end
                end
                default: begin
                    state   <= LOAD;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.features    = slots;
    assign bus.class_out   = class_q;
    assign bus.class_valid = class_valid_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_feature_frame_loader.sv
// tb_feature_frame_loader: scoreboard bench for feature_frame_loader.
// Stimulus pushes the expected outcome of each frame (error pulse, or class
// plus frame contents) into a queue; a monitor pops and compares whenever
// the DUT raises frame_err or class_valid.
module tb_feature_frame_loader;
    localparam int S = 4;

    typedef struct {
        bit           err;
        logic [127:0] feat;
        logic [3:0]   cls;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    feature_frame_loader_if #(.NUM_FEATURES(16), .FEAT_W(8), .CLASS_W(4)) bus ();

    feature_frame_loader #(
        .NUM_FEATURES(16),
        .FEAT_W(8),
        .CLASS_W(4),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    exp_t       sb[$];
    int         passed = 0;
    int         total = 0;
    int         cyc = 0;
    int         fin_cyc = -1000;
    logic [7:0] fb[16];
    bit         ovr_en = 1'b0;
    logic [3:0] ovr = 4'd0;
    bit         auto_ack = 1'b0;
    logic       man_ack = 1'b0;
    logic       cv_prev = 1'b0;

    assign bus.class_ack = auto_ack ? bus.class_valid : man_ack;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Stand-in for the decision tree: class = low nibble of the feature sum.
    function automatic logic [3:0] tree_of(input logic [127:0] f);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(f[i*8 +: 8]);
        return 4'(s);
    endfunction

    function automatic logic [127:0] frame_of_fb();
        logic [127:0] f = '0;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = fb[i];
        return f;
    endfunction

    // Tree output carries a glitch on every cycle except the one just before
    // the sampling edge (S+1 edges after the frame's final transfer).
    always @(posedge clk) begin
        logic [3:0] base;
        #1;
        base = ovr_en ? ovr : tree_of(bus.features);
        bus.class_in = (cyc == fin_cyc + S) ? base : base ^ 4'($urandom_range(15, 1));
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cv_prev = 1'b0;
        end else begin
            if (bus.frame_err) begin
                if (sb.size() == 0) chk("unexpected_frame_err", 128'(1), 128'(0));
                else begin
                    e = sb.pop_front();
                    chk("err_event_kind", 128'(e.err), 128'(1));
                end
            end
            if (bus.class_valid && !cv_prev) begin
                if (sb.size() == 0) chk("unexpected_class_valid", 128'(1), 128'(0));
                else begin
                    e = sb.pop_front();
                    chk("class_event_kind", 128'(e.err), 128'(0));
                    chk("class_out", 128'(bus.class_out), 128'(e.cls));
                    chk("features", bus.features, e.feat);
                    chk("latency", 128'(cyc - fin_cyc), 128'(S + 1));
                    chk("ready_low_in_hold", 128'(bus.in_ready), 128'(0));
                end
            end
            cv_prev = bus.class_valid;
        end
    end

    task automatic push_err();
        exp_t e;
        e.err = 1'b1; e.feat = '0; e.cls = '0;
        sb.push_back(e);
    endtask

    task automatic push_cls();
        exp_t e;
        e.err  = 1'b0;
        e.feat = frame_of_fb();
        e.cls  = ovr_en ? ovr : tree_of(e.feat);
        sb.push_back(e);
    endtask

    // Called and returns at posedge+#1.
    task automatic send_byte(input logic [7:0] d, input bit last, input bit gaps, input bit fin);
        bit ok = 1'b0;
        int n = 0;
        while (gaps && $urandom_range(1, 0) == 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (ok && fin) fin_cyc = cyc + 1;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) chk("ready_timeout", 128'(0), 128'(1));
    endtask

    task automatic send_frame(input int n, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++)
            send_byte(fb[i], (i == last_at), gaps, (n == 16 && last_at == 15 && i == 15));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    task automatic do_ack();
        man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_valid", 128'(bus.class_valid), 128'(0));
        chk("ack_sets_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
    endtask

    task automatic rand_fb();
        for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    endtask

    initial begin
        logic [127:0] exp_feat;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.class_in = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_features", bus.features, 128'(0));
        chk("rst_class_valid", 128'(bus.class_valid), 128'(0));
        chk("rst_class_out", 128'(bus.class_out), 128'(0));
        chk("rst_frame_err", 128'(bus.frame_err), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;

        // Directed frame 0x01..0x10, class 7, long hold before ack
        for (int i = 0; i < 16; i++) fb[i] = 8'(i + 1);
        ovr_en = 1'b1; ovr = 4'd7;
        exp_feat = 128'h100F0E0D0C0B0A090807060504030201;
        push_cls();
        send_frame(16, 15, 1'b0);
        wait_drain(100);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("hold_class_out", 128'(bus.class_out), 128'(7));
            chk("hold_features", bus.features, exp_feat);
            chk("hold_ready", 128'(bus.in_ready), 128'(0));
            chk("hold_valid", 128'(bus.class_valid), 128'(1));
        end
        @(posedge clk); #1;
        do_ack();

        // Early in_last on byte 5, then a clean frame with class 3
        rand_fb();
        push_err();
        send_frame(5, 4, 1'b0);
        rand_fb();
        ovr = 4'd3;
        push_cls();
        send_frame(16, 15, 1'b0);
        wait_drain(200);
        do_ack();

        // 16 bytes with no in_last, then a clean frame classified by the tree
        rand_fb();
        push_err();
        send_frame(16, -1, 1'b0);
        ovr_en = 1'b0;
        rand_fb();
        push_cls();
        send_frame(16, 15, 1'b0);
        wait_drain(200);
        do_ack();

        // Random valid gaps, back-to-back frames, immediate ack
        auto_ack = 1'b1;
        for (int f = 0; f < 20; f++) begin
            rand_fb();
            push_cls();
            send_frame(16, 15, 1'b1);
        end
        wait_drain(2000);
        auto_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while the settle counter sits at 2
        rand_fb();
        push_cls();
        send_frame(16, 15, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("midreset_class_valid", 128'(bus.class_valid), 128'(0));
        chk("midreset_features", bus.features, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        rand_fb();
        ovr_en = 1'b1; ovr = 4'd9;
        push_cls();
        send_frame(16, 15, 1'b1);
        wait_drain(500);
        do_ack();

        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/feature_frame_loader.md
Name: feature_frame_loader

Overview:
- Upstream stage of the printed decision-tree classifier.
- Accepts a byte-serial stream of pendigits features X1..X16 over a valid/ready handshake and assembles them into a parallel frame register.
- Holds the frame stable on the tree inputs, waits a fixed settle time for the combinational tree to resolve, then latches the tree's class output.
- Presents the latched class to the system until it is acknowledged.

Parameters:
- NUM_FEATURES, 16, number of features per frame (X1..X16).
- FEAT_W, 8, width of each feature in bits.
- CLASS_W, 4, width of the classifier output.
- SETTLE_CYCLES, 4, cycles the frame is held on the tree before its output is sampled (1..255).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  FEAT_W  feature byte, in order X1 first.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final feature of a frame.
- in_ready  output  1  loader accepts a byte this cycle.
- features  output  NUM_FEATURES*FEAT_W  frame to the tree; X1 at bits [FEAT_W-1:0], X16 at the MSBs.
- class_in  input  CLASS_W  combinational class from the tree.
- class_out  output  CLASS_W  latched class.
- class_valid  output  1  class_out valid.
- class_ack  input  1  consumer takes class_out.
- frame_err  output  1  one-cycle pulse on a misaligned in_last.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, index=0, features=0, class_out=0, class_valid=0, frame_err=0, settle counter=0.
  - in_ready=1 as soon as reset deasserts.
- State LOAD:
  - in_ready=1.
  - Transfer occurs when in_valid & in_ready. The byte is written to slot index and index increments.
  - Slots are written in place. features shows partial frames during LOAD; downstream ignores the tree output until class_valid.
- Frame completion:
  - Transfer with index==NUM_FEATURES-1 and in_last=1 → index=0, settle counter loaded with SETTLE_CYCLES, state=SETTLE.
- Misalignment:
  - in_last=1 with index<NUM_FEATURES-1, or in_last=0 at index==NUM_FEATURES-1.
  - The byte is written, frame_err pulses the next cycle, index=0, and the state stays LOAD.
  - The frame is discarded and no class is produced.
- State SETTLE:
  - in_ready=0; features frozen.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 0: class_out<=class_in, class_valid<=1, state=HOLD.
  - Latency from the last accepted byte to class_valid is exactly SETTLE_CYCLES+1 cycles.
- State HOLD:
  - in_ready=0; features and class_out stable.
  - On class_ack & class_valid: class_valid<=0, state=LOAD, in_ready=1 the next cycle.
  - class_ack outside HOLD is ignored.
- No overlap: a new frame never starts loading before the previous class is acknowledged. There is no buffering beyond a single frame.
- in_valid while in_ready=0: the byte is not consumed and the producer must hold it (standard valid/ready). in_data and in_last are don't-care when in_valid=0.
- Reset mid-frame or mid-SETTLE/HOLD: all state is cleared immediately and asynchronously. The partial frame is lost and class_valid drops.
- class_in is sampled only in the final SETTLE cycle; glitches on it at other times have no effect.

Test Plan:
- Reset, then stream 16 bytes 0x01..0x10 with in_last on byte 16, SETTLE_CYCLES=4, class_in=4'd7 → features={0x10,...,0x01}. class_valid rises exactly 5 cycles after the last transfer with class_out=7, and in_ready=0 until ack.
- Hold class_ack low for 20 cycles → class_out and features are unchanged. Pulse ack → class_valid=0 and in_ready=1 the next cycle.
- in_last on byte 5 → frame_err single pulse, no class_valid. Then a clean 16-byte frame with class_in=3 → class_out=3.
- 16 bytes without in_last → frame_err pulse and index reset. The next 16-byte frame with correct in_last produces class_valid.
- Random in_valid gaps (50% duty) and back-to-back frames with immediate ack → every frame is classified in order. No byte is lost or duplicated, and no transfer occurs while in_ready=0.
- Assert rst_n=0 during SETTLE (counter=2) → class_valid=0, features=0, in_ready=1 after release, and a fresh frame loads from X1.
